alien_formation_motion: RTL and testbench
=========================================

Name: alien_formation_motion

Overview:
- Drives the formation origin (group_lhpos, group_tvpos) and per-frame speed consumed by every alien instance in the alien group.
- Moves the formation sideways each move tick. When the outermost living column would cross a playfield edge, it clamps, steps down, and reverses direction.
- Speed rises as aliens are killed.
- Updates only on fsync, so positions are stable for a whole frame.

Parameters:
- ROWS, 4, formation rows.
- COLS, 8, formation columns.
- START_X, 64, group_lhpos after reset.
- START_Y, 48, group_tvpos after reset.
- H_MIN, 0, leftmost legal pixel column.
- H_MAX, 639, rightmost legal pixel column.
- V_LIMIT, 440, pixel row at or below which the formation has landed.
- STEP_DOWN, 16, pixels descended per edge hit.
- MOVE_DIV, 1, frames per move tick (1..255).
- BASE_SPEED, 1, pixels per move tick with zero kills.
- SPEED_SHIFT, 2, kills are divided by 2^SPEED_SHIFT before being added to speed.
- MAX_SPEED, 4, speed saturation value.
- Geometry ENEMY_W, ENEMY_H, SPACING_X, SPACING_Y is taken from the params package. Define PITCH_X = ENEMY_W+SPACING_X and PITCH_Y = ENEMY_H+SPACING_Y.

Ports:
- pixel_clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- fsync  in  1  one-cycle frame-start pulse.
- start  in  1  leaves IDLE; ignored in any other state.
- alive_mask  in  ROWS*COLS  bit r*COLS+c = alien (r,c) alive.
- group_lhpos  out  12 signed  formation left origin.
- group_tvpos  out  12 signed  formation top origin.
- speed  out  8  current pixels per move tick.
- dir_left  out  1  0 = moving right, 1 = moving left.
- reached_bottom  out  1  sticky; set when the formation lands.
- all_dead  out  1  alive_mask == 0, registered on fsync.

Behaviour:
- Clock is pixel_clk; reset rst is synchronous and active-high. All state changes occur on pixel_clk edges. Apart from start in IDLE, state only advances on cycles where fsync=1.
- Reset values: group_lhpos=START_X, group_tvpos=START_Y, speed=BASE_SPEED, dir_left=0, reached_bottom=0, all_dead=0, frame counter=0, state=IDLE.
- Reset asserted mid-operation, in any state, restores all reset values on the next edge.
- Combinational helpers, computed from the current alive_mask:
  - lcol / rcol = lowest / highest column containing a live alien.
  - brow = highest row containing a live alien.
  - left_off = lcol*PITCH_X.
  - right_off = rcol*PITCH_X + ENEMY_W - 1.
  - bot_off = brow*PITCH_Y + ENEMY_H - 1.
  - All in 12-bit signed arithmetic. Helpers are don't-care when the mask is zero.
- kills = ROWS*COLS - popcount(alive_mask).
- Speed is registered on every fsync in MOVE and DESCEND as min(BASE_SPEED + (kills >> SPEED_SHIFT), MAX_SPEED). The new speed takes effect at the next tick.
- Move tick is fsync=1 with frame counter == MOVE_DIV-1. The counter wraps to 0 on a tick and otherwise increments on each fsync in MOVE and DESCEND.
- States:
  - IDLE: outputs held. start=1 -> MOVE, with the frame counter cleared.
  - MOVE, on a tick, with nxt = group_lhpos ± speed:
    - Moving right and nxt + right_off > H_MAX: group_lhpos = H_MAX - right_off, then DESCEND.
    - Moving left and nxt + left_off < H_MIN: group_lhpos = H_MIN - left_off (may be negative), then DESCEND.
    - Otherwise: group_lhpos = nxt.
  - DESCEND, on the next tick:
    - group_tvpos += STEP_DOWN, dir_left toggles, group_lhpos unchanged.
    - If the new group_tvpos + bot_off >= V_LIMIT, go to LANDED; otherwise back to MOVE.
  - LANDED: reached_bottom=1. Positions and speed frozen until reset.
  - CLEARED: all positions frozen until reset.
- Priority on an fsync in MOVE or DESCEND:
  - If alive_mask == 0: set all_dead=1 and go to CLEARED; no motion that frame.
  - Otherwise the landing check takes precedence over the edge check.
- The mask is sampled on the same fsync used for motion. A column dying on a tick frame affects that tick's edge computation.

Test Plan:
Bench geometry: ENEMY_W=32, ENEMY_H=24, SPACING_X=16, SPACING_Y=16; other parameters at defaults.
- Reset -> lhpos=64, tvpos=48, speed=1, dir_left=0. Start, all alive, 3 fsyncs -> lhpos 65, 66, 67.
- All alive, right_off=367 -> lhpos never exceeds 272. With lhpos=271 and speed=2, the tick gives lhpos=272 -> DESCEND. Next tick: tvpos=64, dir_left=1, lhpos=272.
- Clear column 7 in all rows, right_off=319 -> right clamp at 320. Clear columns 0..1, moving left -> clamp at H_MIN-96 = -96 (signed).
- Kill 8 -> speed=3 (1+8>>2); kill 12 -> speed=4; kill 20 -> speed stays 4 (saturated). Speed changes only after an fsync.
- tvpos=288, all rows alive, bot_off=143, descend -> tvpos=304, 304+143>=440 -> LANDED. reached_bottom=1, lhpos/tvpos frozen over 10 fsyncs.
- Mask -> 0 on an fsync -> all_dead=1, positions frozen. Rst asserted during DESCEND -> lhpos=64, tvpos=48, state IDLE the next cycle; start ignored until then.

Source files
------------

// File: rtl/alien_formation_motion.sv
// alien_formation_motion
//   Owns the formation origin shared by every alien instance. Each move tick the
//   formation slides sideways by `speed` pixels. When the outermost living column
//   would leave the playfield, the formation clamps to the edge. On the following
//   tick it steps down and reverses direction. Speed grows with the kill count.
//   State changes only on fsync, except for leaving IDLE on start, so the
//   positions stay stable for a whole frame.
//
// Ports
//   pixel_clk       pixel clock
//   rst             synchronous, active-high reset
//   fsync           one-cycle frame-start pulse
//   start           leaves IDLE; ignored in every other state
//   alive_mask      bit r*COLS+c set = alien (r,c) alive
//   group_lhpos     signed formation left origin
//   group_tvpos     signed formation top origin
//   speed           pixels per move tick
//   dir_left        0 = moving right, 1 = moving left
//   reached_bottom  sticky landing flag
//   all_dead        alive_mask == 0, registered on fsync

package alien_params_pkg;
  localparam int ENEMY_W   = 32;
  localparam int ENEMY_H   = 24;
  localparam int SPACING_X = 16;
  localparam int SPACING_Y = 16;
endpackage

module alien_formation_motion
  import alien_params_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 8,
  parameter int START_X     = 64,
  parameter int START_Y     = 48,
  parameter int H_MIN       = 0,
  parameter int H_MAX       = 639,
  parameter int V_LIMIT     = 440,
  parameter int STEP_DOWN   = 16,
  parameter int MOVE_DIV    = 1,
  parameter int BASE_SPEED  = 1,
  parameter int SPEED_SHIFT = 2,
  parameter int MAX_SPEED   = 4
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   fsync,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   alive_mask,
  output logic signed [11:0]     group_lhpos,
  output logic signed [11:0]     group_tvpos,
  output logic [7:0]             speed,
  output logic                   dir_left,
  output logic                   reached_bottom,
  output logic                   all_dead
);

  localparam int PITCH_X = ENEMY_W + SPACING_X;
  localparam int PITCH_Y = ENEMY_H + SPACING_Y;

  localparam logic signed [11:0] START_X_S = 12'(START_X);
  localparam logic signed [11:0] START_Y_S = 12'(START_Y);
  localparam logic signed [11:0] H_MIN_S   = 12'(H_MIN);
  localparam logic signed [11:0] H_MAX_S   = 12'(H_MAX);
  localparam logic signed [11:0] V_LIMIT_S = 12'(V_LIMIT);
  localparam logic signed [11:0] STEP_S    = 12'(STEP_DOWN);

  typedef enum logic [2:0] {IDLE, MOVE, DESCEND, LANDED, CLEARED} state_t;

  state_t state_q, state_d;

  logic [7:0]         frame_cnt, frame_cnt_d;
  logic signed [11:0] lhpos_d, tvpos_d;
  logic [7:0]         speed_d;
  logic               dir_left_d, reached_bottom_d, all_dead_d;

  // Extent of the living formation, relative to the origin.
  logic [COLS-1:0]    col_any;
  logic [ROWS-1:0]    row_any;
  int                 lcol, rcol, brow;
  logic signed [11:0] left_off, right_off, bot_off;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    col_any = '0;
    row_any = '0;
    lcol    = 0;
    rcol    = 0;
    brow    = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (alive_mask[r*COLS+c]) begin
          col_any[c] = 1'b1;
          row_any[r] = 1'b1;
        end
      end
    end
    // The downward scan leaves the lowest live column. The upward scans leave
    // the highest live column and the highest live row.
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = c;
    for (int c = 0; c < COLS; c++)      if (col_any[c]) rcol = c;
    for (int r = 0; r < ROWS; r++)      if (row_any[r]) brow = r;
  end

  assign left_off  = 12'(lcol * PITCH_X);
  assign right_off = 12'(rcol * PITCH_X + ENEMY_W - 1);
  assign bot_off   = 12'(brow * PITCH_Y + ENEMY_H - 1);

  // Speed from the kill count, saturated.
  int         kills, spd_int;
  logic [7:0] speed_calc;

  always_comb begin
    kills   = ROWS * COLS - $countones(alive_mask);
    spd_int = BASE_SPEED + (kills >> SPEED_SHIFT);
    if (spd_int > MAX_SPEED) spd_int = MAX_SPEED;
  end
  assign speed_calc = 8'(spd_int);

  logic               tick;
  logic signed [11:0] spd_s, nxt, tv_step;

  assign tick    = fsync && (frame_cnt == 8'(MOVE_DIV - 1));
  assign spd_s   = $signed({4'b0000, speed});
  assign nxt     = dir_left ? (group_lhpos - spd_s) : (group_lhpos + spd_s);
  assign tv_step = group_tvpos + STEP_S;

  always_comb begin
    state_d          = state_q;
    frame_cnt_d      = frame_cnt;
    lhpos_d          = group_lhpos;
    tvpos_d          = group_tvpos;
    speed_d          = speed;
    dir_left_d       = dir_left;
    reached_bottom_d = reached_bottom;
    all_dead_d       = all_dead;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = MOVE;
          frame_cnt_d = '0;
        end
      end

      MOVE, DESCEND: begin
        if (fsync) begin
          speed_d     = speed_calc;
          frame_cnt_d = tick ? 8'd0 : frame_cnt + 8'd1;
          if (alive_mask == '0) begin
            // An empty formation has no extent, so no motion happens this frame.
            all_dead_d = 1'b1;
            state_d    = CLEARED;
          end else if (tick) begin
            if (state_q == DESCEND) begin
              tvpos_d    = tv_step;
              dir_left_d = ~dir_left;
              if (tv_step + bot_off >= V_LIMIT_S) begin
                reached_bottom_d = 1'b1;
                state_d          = LANDED;
              end else begin
                state_d = MOVE;
              end
            end else if (!dir_left && (nxt + right_off > H_MAX_S)) begin
              lhpos_d = H_MAX_S - right_off;
              state_d = DESCEND;
            end else if (dir_left && (nxt + left_off < H_MIN_S)) begin
              // The origin may go negative when the left columns are dead.
              lhpos_d = H_MIN_S - left_off;
              state_d = DESCEND;
            end else begin
              lhpos_d = nxt;
            end
          end
        end
      end

      LANDED, CLEARED: ;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q        <= IDLE;
      frame_cnt      <= '0;
      group_lhpos    <= START_X_S;
      group_tvpos    <= START_Y_S;
      speed          <= 8'(BASE_SPEED);
      dir_left       <= 1'b0;
      reached_bottom <= 1'b0;
      all_dead       <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt      <= frame_cnt_d;
      group_lhpos    <= lhpos_d;
      group_tvpos    <= tvpos_d;
      speed          <= speed_d;
      dir_left       <= dir_left_d;
      reached_bottom <= reached_bottom_d;
      all_dead       <= all_dead_d;
    end
  end

endmodule

// File: tb/tb_alien_formation_motion.sv
// Directed bench for alien_formation_motion. Expected observations are pushed
// to a queue when a frame is driven, and popped and compared once the DUT has
// taken that frame. The edge positions used below follow from the bench
// geometry (pitch 48x40, enemy 32x24): right edge 272 for all columns, 320 with
// column 7 dead, -96 with columns 0..1 dead, landing at tvpos 304.
module tb_alien_formation_motion;

  logic               pixel_clk = 1'b0;
  logic               rst;
  logic               fsync;
  logic               start;
  logic [31:0]        alive_mask;
  logic signed [11:0] group_lhpos, group_tvpos;
  logic [7:0]         speed;
  logic               dir_left, reached_bottom, all_dead;

  alien_formation_motion dut (
    .pixel_clk      (pixel_clk),
    .rst            (rst),
    .fsync          (fsync),
    .start          (start),
    .alive_mask     (alive_mask),
    .group_lhpos    (group_lhpos),
    .group_tvpos    (group_tvpos),
    .speed          (speed),
    .dir_left       (dir_left),
    .reached_bottom (reached_bottom),
    .all_dead       (all_dead)
  );

  always #5 pixel_clk = ~pixel_clk;

  localparam logic [31:0] M_ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] M_K4  = 32'hFFFF_FFC3;  // row 0 cols 2..5 dead
  localparam logic [31:0] M_C01 = 32'hFCFC_FCFC;  // cols 0,1 dead: 8 kills
  localparam logic [31:0] M_C7  = 32'h7C7C_7C7C;  // cols 0,1,7 dead: 12 kills
  localparam logic [31:0] M_K20 = 32'h7C7C_4040;  // 20 kills, cols 2..6, row 3 alive

  typedef struct packed {
    logic signed [11:0] lh;
    logic signed [11:0] tv;
    logic               dir;
    logic [7:0]         spd;
    logic               rb;
    logic               ad;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   e_lh, e_tv, e_spd;
  logic e_dir, e_rb, e_ad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int spd_of(input logic [31:0] m);
    int s;
    s = 1 + ((32 - $countones(m)) >> 2);
    return (s > 4) ? 4 : s;
  endfunction

  task automatic model_reset();
    e_lh = 64; e_tv = 48; e_spd = 1; e_dir = 1'b0; e_rb = 1'b0; e_ad = 1'b0;
  endtask

  // Drive one fsync frame. The caller sets the e_* model to the expected
  // post-frame values first. Entered and left on a falling edge.
  task automatic fsync_step(input logic [31:0] m, input string tag);
    obs_t o, e;
    exp_q.push_back(obs_t'{12'(e_lh), 12'(e_tv), e_dir, 8'(e_spd), e_rb, e_ad});
    alive_mask = m;
    fsync      = 1'b1;
    @(negedge pixel_clk);
    fsync = 1'b0;
    @(negedge pixel_clk);
    o = {group_lhpos, group_tvpos, dir_left, speed, reached_bottom, all_dead};
    e = exp_q.pop_front();
    check(tag, 64'(o), 64'(e));
  endtask

  // Move sideways until the edge clamp at position lim. lim is the clamped
  // origin for the current mask and direction.
  task automatic leg(input logic [31:0] m, input int lim, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      int nxt = e_dir ? e_lh - e_spd : e_lh + e_spd;
      if (e_dir ? (nxt < lim) : (nxt > lim)) begin
        nxt = lim;
        hit = 1'b1;
      end
      e_lh  = nxt;
      e_spd = spd_of(m);
      fsync_step(m, tag);
    end
    check({tag, "_edge"}, 64'(group_lhpos), 64'(lim));
  endtask

  // Descend tick: bot_off is 143 for every mask used, since row 3 is alive.
  task automatic descend(input logic [31:0] m, input string tag);
    e_tv  = e_tv + 16;
    e_dir = ~e_dir;
    e_spd = spd_of(m);
    if (e_tv + 143 >= 440) e_rb = 1'b1;
    fsync_step(m, tag);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge pixel_clk);
    start = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; fsync = 1'b0;
    @(negedge pixel_clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fsync = 1'b0; start = 1'b0; alive_mask = M_ALL;
    repeat (2) @(negedge pixel_clk);
    rst = 1'b0;
    model_reset();

    check("rst_lh",  64'(group_lhpos),   64'(64));
    check("rst_tv",  64'(group_tvpos),   64'(48));
    check("rst_spd", 64'(speed),         64'(1));
    check("rst_dir", 64'(dir_left),      64'(0));
    check("rst_rb",  64'(reached_bottom),64'(0));
    check("rst_ad",  64'(all_dead),      64'(0));

    // Basic motion, all alive.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      e_lh = e_lh + 1;
      fsync_step(M_ALL, "move_right");
    end
    // The kill frame still moves by the old speed. The speed rises to 2 after it.
    e_lh = 69; e_spd = 2;
    fsync_step(M_K4, "k4_frame");
    check("spd_k4", 64'(speed), 64'(2));

    // Right edge with all columns alive: 271 + 2 overshoots, clamped to 272.
    leg(M_K4, 272, "right_all");
    descend(M_K4, "desc1");
    check("desc1_tv",  64'(group_tvpos), 64'(64));
    check("desc1_dir", 64'(dir_left),    64'(1));
    check("desc1_lh",  64'(group_lhpos), 64'(272));

    e_lh = 270;
    fsync_step(M_K4, "left_first");

    // The mask changes with no fsync, so the speed must not move yet.
    alive_mask = M_C01;
    repeat (3) @(negedge pixel_clk);
    check("spd_hold", 64'(speed), 64'(2));

    // Left edge with columns 0..1 dead: clamp at -96.
    leg(M_C01, -96, "left_c01");
    check("spd_k8", 64'(speed), 64'(3));
    descend(M_C01, "desc2");

    // Right edge with column 7 also dead: clamp at 320.
    leg(M_C7, 320, "right_c7");
    check("spd_k12", 64'(speed), 64'(4));
    descend(M_C7, "desc3");

    // Bounce with 20 kills until the formation lands.
    for (int n = 0; n < 20 && !e_rb; n++) begin
      leg(M_K20, e_dir ? -96 : 320, "bounce");
      descend(M_K20, "bounce_desc");
    end
    check("land_tv",  64'(group_tvpos),    64'(304));
    check("land_rb",  64'(reached_bottom), 64'(1));
    check("spd_k20",  64'(speed),          64'(4));
    repeat (10) fsync_step(M_K20, "landed_frozen");

    // Formation cleared.
    reset_dut();
    pulse_start();
    e_lh = 65;
    fsync_step(M_ALL, "pre_clear");
    e_ad = 1'b1; e_spd = 4;
    fsync_step(32'h0, "clear");
    repeat (3) fsync_step(32'h0, "cleared_frozen");

    // Reset while in DESCEND, with start asserted during reset.
    reset_dut();
    pulse_start();
    leg(M_ALL, 272, "rst_leg");
    rst = 1'b1; start = 1'b1; fsync = 1'b1;
    @(negedge pixel_clk);
    rst = 1'b0; start = 1'b0; fsync = 1'b0;
    model_reset();
    check("rst_mid_lh",  64'(group_lhpos), 64'(64));
    check("rst_mid_tv",  64'(group_tvpos), 64'(48));
    check("rst_mid_dir", 64'(dir_left),    64'(0));
    fsync_step(M_ALL, "idle_hold");
    pulse_start();
    e_lh = 65;
    fsync_step(M_ALL, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
